// File: rtl/axil_stat_regs.sv
`default_nettype none
// ============================================================================
// Module   : axil_stat_regs
// Purpose  : AXI4-Lite register block with RW control registers, a
//            write-1-pulse register, a read-only ID register and 64-bit
//            read-only status counters read through a low/high shadow
//            scheme. The shadow scheme keeps a 64-bit read coherent.
//
// Address map (decoded on addr[7:2], addr[1:0] ignored):
//   0x00        ID      (RO, returns VERSION)
//   0x08        PULSE   (WO, reads 0)
//   0x10 + 4i   CTRL i  (RW, byte-masked by wstrb)
//   0x40 + 8j   STAT j low word  (RO, also captures high word into shadow j)
//   0x44 + 8j   STAT j high word (RO, returns shadow j)
//
// Ports:
//   clk, rst           sole clock, synchronous active-high reset
//   s_axil_aw*/w*/b*   AXI4-Lite write channels (8-bit address, 32-bit data)
//   s_axil_ar*/r*      AXI4-Lite read channels
//   ctrl_out           control register contents, reg i at [32i+31:32i]
//   pulse_out          one-cycle pulse outputs from PULSE writes
//   stat_in            live counters, counter j at [64j+63:64j]
//
// Configuration:
//   AXIL_STAT_REGS_SLVERR_EN  when defined, unmapped reads return SLVERR and
//                             writes to unmapped or RO addresses return
//                             SLVERR. When undefined, all responses are OKAY.
//
// Parameters: NUM_CTRL (1..8), NUM_STAT (1..16), CTRL_RESET, VERSION.
//
// Revision : 1.0 - initial release
// ============================================================================
module axil_stat_regs #(
  parameter int          NUM_CTRL   = 2,
  parameter int          NUM_STAT   = 8,
  parameter logic [31:0] CTRL_RESET = 32'h1,
  parameter logic [31:0] VERSION    = 32'h0002_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  // write address channel
  input  logic [7:0]               s_axil_awaddr,
  input  logic                     s_axil_awvalid,
  output logic                     s_axil_awready,
  // write data channel
  input  logic [31:0]              s_axil_wdata,
  input  logic [3:0]               s_axil_wstrb,
  input  logic                     s_axil_wvalid,
  output logic                     s_axil_wready,
  // write response channel
  output logic [1:0]               s_axil_bresp,
  output logic                     s_axil_bvalid,
  input  logic                     s_axil_bready,
  // read address channel
  input  logic [7:0]               s_axil_araddr,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  // read data channel
  output logic [31:0]              s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  // register side
  output logic [NUM_CTRL*32-1:0]   ctrl_out,
  output logic [31:0]              pulse_out,
  input  logic [NUM_STAT*64-1:0]   stat_in
);

`ifdef AXIL_STAT_REGS_SLVERR_EN
  localparam logic c_slverr_en = 1'b1;
`else
  localparam logic c_slverr_en = 1'b0;
`endif

  // Word indices (address bits [7:2])
  localparam logic [5:0] c_idx_id    = 6'd0;
  localparam logic [5:0] c_idx_pulse = 6'd2;
  localparam int         c_ctrl_base = 4;
  localparam int         c_stat_base = 16;

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wr_state_t            r_wstate;
  logic                 r_aw_held;
  logic [5:0]           r_aw_idx;
  logic                 r_w_held;
  logic [31:0]          r_wdata;
  logic [3:0]           r_wstrb;
  logic                 r_bvalid;
  logic [1:0]           r_bresp;
  logic [31:0]          r_pulse;
  logic [31:0]          r_ctrl   [NUM_CTRL];

  logic [NUM_STAT*64-1:0] r_stat;
  logic [31:0]          r_shadow [NUM_STAT];

  rd_state_t            r_rstate;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;
  logic [1:0]           r_rresp;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_ar_hs;
  logic                 w_wr_fire;
  logic                 w_wr_ok;
  logic [31:0]          w_wr_mask;
  logic [5:0]           w_rd_idx;
  logic [31:0]          w_rd_data;
  logic                 w_rd_err;
  logic                 w_unused;

  // Address byte-offset bits carry no meaning in a word-addressed map.
  assign w_unused = &{1'b0, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Readies are forced low while rst is high so nothing is accepted during
  // reset; they come up in the first cycle rst is low.
  assign s_axil_awready = !rst && (r_wstate == W_IDLE) && !r_aw_held;
  assign s_axil_wready  = !rst && (r_wstate == W_IDLE) && !r_w_held;
  assign s_axil_arready = !rst && (r_rstate == R_IDLE);

  assign w_aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_w_hs    = s_axil_wvalid  && s_axil_wready;
  assign w_ar_hs   = s_axil_arvalid && s_axil_arready;
  assign w_wr_fire = (r_wstate == W_IDLE) && r_aw_held && r_w_held;

  assign w_wr_mask = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}},
                      {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};

  // A write is "ok" only for addresses that accept writes (PULSE, CTRL).
  always_comb begin
    w_wr_ok = (r_aw_idx == c_idx_pulse);
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (r_aw_idx == 6'(c_ctrl_base + i)) w_wr_ok = 1'b1;
    end
  end

  assign w_rd_idx = s_axil_araddr[7:2];

  // Read mux; anything not matched below is unmapped and reads as zero.
  always_comb begin
    w_rd_data = 32'h0;
    w_rd_err  = 1'b1;
    if (w_rd_idx == c_idx_id) begin
      w_rd_data = VERSION;
      w_rd_err  = 1'b0;
    end
    if (w_rd_idx == c_idx_pulse) begin
      w_rd_err  = 1'b0;
    end
    for (int i = 0; i < NUM_CTRL; i++) begin
      if (w_rd_idx == 6'(c_ctrl_base + i)) begin
        w_rd_data = r_ctrl[i];
        w_rd_err  = 1'b0;
      end
    end
    for (int j = 0; j < NUM_STAT; j++) begin
      if (w_rd_idx == 6'(c_stat_base + 2*j)) begin
        w_rd_data = r_stat[j*64 +: 32];
        w_rd_err  = 1'b0;
      end
      if (w_rd_idx == 6'(c_stat_base + 2*j + 1)) begin
        w_rd_data = r_shadow[j];
        w_rd_err  = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write channel FSM, control registers and pulse register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_aw_idx  <= 6'h0;
      r_w_held  <= 1'b0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_resp_okay;
      r_pulse   <= 32'h0;
      for (int i = 0; i < NUM_CTRL; i++) r_ctrl[i] <= CTRL_RESET;
    end else begin
      // Pulse lasts exactly one cycle unless a new PULSE write lands.
      r_pulse <= 32'h0;
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_aw_idx  <= s_axil_awaddr[7:2];
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axil_wdata;
            r_wstrb  <= s_axil_wstrb;
          end
          if (w_wr_fire) begin
            for (int i = 0; i < NUM_CTRL; i++) begin
              if (r_aw_idx == 6'(c_ctrl_base + i)) begin
                r_ctrl[i] <= (r_ctrl[i] & ~w_wr_mask) | (r_wdata & w_wr_mask);
              end
            end
            if (r_aw_idx == c_idx_pulse) r_pulse <= r_wdata & w_wr_mask;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= (c_slverr_en && !w_wr_ok) ? c_resp_slverr : c_resp_okay;
            r_wstate  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_axil_bready) begin
            r_bvalid <= 1'b0;
            r_bresp  <= c_resp_okay;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Status sampling, read channel FSM and shadow capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat   <= '0;
      r_rstate <= R_IDLE;
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_rresp  <= c_resp_okay;
      for (int j = 0; j < NUM_STAT; j++) r_shadow[j] <= 32'h0;
    end else begin
      r_stat <= stat_in;
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata  <= w_rd_data;
            r_rresp  <= (c_slverr_en && w_rd_err) ? c_resp_slverr : c_resp_okay;
            r_rvalid <= 1'b1;
            r_rstate <= R_DATA;
            // Low-word read freezes the matching high word so that a later
            // high-word read returns a value coherent with this low word.
            for (int j = 0; j < NUM_STAT; j++) begin
              if (w_rd_idx == 6'(c_stat_base + 2*j)) begin
                r_shadow[j] <= r_stat[j*64+32 +: 32];
              end
            end
          end
        end
        R_DATA: begin
          if (s_axil_rready) begin
            r_rvalid <= 1'b0;
            r_rstate <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rdata  = r_rdata;
  assign s_axil_rresp  = r_rresp;
  assign pulse_out     = r_pulse;

  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl_out
    assign ctrl_out[gi*32 +: 32] = r_ctrl[gi];
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_stat_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_stat_regs
// Purpose  : Directed self-checking bench for axil_stat_regs (default
//            parameters). Expected response codes follow the
//            AXIL_STAT_REGS_SLVERR_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_stat_regs;

  localparam int NUM_CTRL = 2;
  localparam int NUM_STAT = 8;

`ifdef AXIL_STAT_REGS_SLVERR_EN
  localparam logic [1:0] c_exp_err = 2'b10;
`else
  localparam logic [1:0] c_exp_err = 2'b00;
`endif

  logic                   clk;
  logic                   rst;
  logic [7:0]             awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [7:0]             araddr;
  logic                   arvalid;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready;
  logic [NUM_CTRL*32-1:0] ctrl_out;
  logic [31:0]            pulse_out;
  logic [NUM_STAT*64-1:0] stat_in;

  int checks = 0;
  int errors = 0;

  // Results of the last write transaction
  int          wr_nb;
  logic [1:0]  wr_resp;
  int          pulse_cnt;
  logic [31:0] pulse_val;

  axil_stat_regs #(
    .NUM_CTRL  (NUM_CTRL),
    .NUM_STAT  (NUM_STAT),
    .CTRL_RESET(32'h1),
    .VERSION   (32'h0002_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axil_awaddr (awaddr),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata  (wdata),
    .s_axil_wstrb  (wstrb),
    .s_axil_wvalid (wvalid),
    .s_axil_wready (wready),
    .s_axil_bresp  (bresp),
    .s_axil_bvalid (bvalid),
    .s_axil_bready (bready),
    .s_axil_araddr (araddr),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata  (rdata),
    .s_axil_rresp  (rresp),
    .s_axil_rvalid (rvalid),
    .s_axil_rready (rready),
    .ctrl_out      (ctrl_out),
    .pulse_out     (pulse_out),
    .stat_in       (stat_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write with independent AW/W start delays (in cycles); then watch the
  // B channel and pulse_out for a fixed window with bready held high.
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly, input int w_dly);
    int   cyc;
    logic aw_done, w_done, hs_aw, hs_w;
    cyc = 0; aw_done = 1'b0; w_done = 1'b0;
    wr_nb = 0; wr_resp = 2'bxx; pulse_cnt = 0; pulse_val = 32'h0;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = a; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      @(negedge clk);
      cyc++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bvalid === 1'b1) begin wr_nb++; wr_resp = bresp; end
      if (pulse_out !== 32'h0) begin pulse_cnt++; pulse_val = pulse_out; end
      @(negedge clk);
    end
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d,
                          output logic [1:0] r, output logic lat_ok);
    int cyc;
    cyc = 0;
    arvalid = 1'b1;
    araddr  = a;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    arvalid = 1'b0;
    lat_ok  = rvalid;
    cyc = 0;
    while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
    d = rvalid ? rdata : 32'hDEAD_0000;
    r = rvalid ? rresp : 2'bxx;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [1:0]  rr;
  logic        lat;
  int          nb;

  initial begin
    rst = 1'b1; awaddr = 8'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    wvalid = 1'b0; bready = 1'b1; araddr = 8'h0; arvalid = 1'b0; rready = 1'b1;
    stat_in = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_pulse", pulse_out, 0);
    check("rst_ctrl", ctrl_out, {32'h1, 32'h1});
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_awready", awready, 1);
    check("post_rst_wready", wready, 1);
    check("post_rst_arready", arready, 1);

    // ID and CTRL reset value
    axi_read(8'h00, rd, rr, lat);
    check("id_rdata", rd, 32'h0002_0000);
    check("id_rresp", rr, 2'b00);
    check("rd_latency", lat, 1);
    axi_read(8'h10, rd, rr, lat);
    check("ctrl0_reset", rd, 32'h1);

    // W three cycles ahead of AW, byte-masked CTRL write
    axi_write(8'h14, 32'hAABB_CCDD, 4'b0101, 3, 0);
    check("wstrb_nb", wr_nb, 1);
    check("wstrb_bresp", wr_resp, 2'b00);
    axi_read(8'h14, rd, rr, lat);
    check("wstrb_rdata", rd, 32'h00BB_00DD);
    check("wstrb_ctrl_out", ctrl_out[63:32], 32'h00BB_00DD);

    // AW and W together, then AW ahead of W; addr[1:0] ignored on read
    axi_write(8'h10, 32'h1234_5678, 4'hF, 0, 0);
    check("same_cyc_nb", wr_nb, 1);
    axi_write(8'h11, 32'h0000_00EE, 4'b0001, 0, 2);
    check("aw_first_nb", wr_nb, 1);
    axi_read(8'h13, rd, rr, lat);
    check("ctrl0_rdata", rd, 32'h1234_56EE);

    // Status shadow coherence
    stat_in[63:0] = 64'h0000_0001_FFFF_FFFF;
    repeat (2) @(negedge clk);
    axi_read(8'h40, rd, rr, lat);
    check("stat0_lo", rd, 32'hFFFF_FFFF);
    stat_in[63:0] = 64'h0000_0002_0000_0000;
    repeat (2) @(negedge clk);
    axi_read(8'h44, rd, rr, lat);
    check("stat0_hi_shadow", rd, 32'h0000_0001);
    axi_read(8'h40, rd, rr, lat);
    check("stat0_lo2", rd, 32'h0000_0000);
    axi_read(8'h44, rd, rr, lat);
    check("stat0_hi2", rd, 32'h0000_0002);
    stat_in[511:448] = 64'hDEAD_BEEF_0123_4567;
    repeat (2) @(negedge clk);
    axi_read(8'h78, rd, rr, lat);
    check("stat7_lo", rd, 32'h0123_4567);
    axi_read(8'h7C, rd, rr, lat);
    check("stat7_hi", rd, 32'hDEAD_BEEF);

    // Pulse register
    axi_write(8'h08, 32'h5, 4'hF, 0, 0);
    check("pulse_cnt", pulse_cnt, 1);
    check("pulse_val", pulse_val, 32'h5);
    check("pulse_bresp", wr_resp, 2'b00);
    axi_write(8'h08, 32'h0000_1234, 4'b0001, 0, 1);
    check("pulse_mask_val", pulse_val, 32'h34);
    axi_read(8'h08, rd, rr, lat);
    check("pulse_read", rd, 32'h0);
    check("pulse_rresp", rr, 2'b00);

    // Unmapped and read-only accesses
    axi_read(8'hFC, rd, rr, lat);
    check("unmapped_rdata", rd, 32'h0);
    check("unmapped_rresp", rr, c_exp_err);
    axi_read(8'h18, rd, rr, lat);
    check("gap_rresp", rr, c_exp_err);
    axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0);
    check("ro_bresp", wr_resp, c_exp_err);
    axi_read(8'h00, rd, rr, lat);
    check("ro_unchanged", rd, 32'h0002_0000);
    axi_write(8'h30, 32'hFFFF_FFFF, 4'hF, 0, 0);
    check("unmapped_bresp", wr_resp, c_exp_err);
    check("unmapped_ctrl", ctrl_out, {32'h00BB_00DD, 32'h1234_56EE});

    // Same-cycle read and write of CTRL0: read returns pre-write value
    awvalid = 1'b1; awaddr = 8'h10; wvalid = 1'b1; wdata = 32'h9ABC_DEF0; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 8'h10;
    @(negedge clk);
    arvalid = 1'b0;
    check("rw_rvalid", rvalid, 1);
    check("rw_rdata_old", rdata, 32'h1234_56EE);
    check("rw_bvalid", bvalid, 1);
    @(negedge clk);
    axi_read(8'h10, rd, rr, lat);
    check("rw_rdata_new", rd, 32'h9ABC_DEF0);

    // Reset while a B response is pending
    bready = 1'b0;
    awvalid = 1'b1; awaddr = 8'h10; wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 10 && bvalid !== 1'b1; k++) @(negedge clk);
    check("abort_bvalid_pending", bvalid, 1);
    check("abort_ctrl_written", ctrl_out[31:0], 32'hCAFE_F00D);
    rst = 1'b1;
    @(negedge clk);
    check("abort_bvalid_cleared", bvalid, 0);
    check("abort_ctrl_reset", ctrl_out, {32'h1, 32'h1});
    rst = 1'b0;
    bready = 1'b1;
    nb = 0;
    for (int k = 0; k < 8; k++) begin
      if (bvalid !== 1'b0) nb++;
      @(negedge clk);
    end
    check("abort_no_resp", nb, 0);
    check("abort_awready", awready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axil_stat_regs.md
AXIL_STAT_REGS -- requirements
Module: axil_stat_regs

Interface
REQ-001 SHALL have parameter NUM_CTRL, default 2, number of 32-bit RW control registers (1..8).
REQ-002 SHALL have parameter NUM_STAT, default 8, number of 64-bit RO status counters (1..16).
REQ-003 SHALL have parameter CTRL_RESET, default 32'h1, reset value of every control register.
REQ-004 SHALL have parameter VERSION, default 32'h0002_0000, value of the ID register.
REQ-005 SHALL have ports:
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- s_axil_aw*/w*/b*/ar*/r*  AXI4-Lite slave, 8-bit addresses, 32-bit data, 4-bit wstrb
- ctrl_out  out  NUM_CTRL*32  control register contents, reg i at [32i+31:32i]
- pulse_out  out  32  one-cycle write-1-pulse outputs
- stat_in  in  NUM_STAT*64  live counters, counter j at [64j+63:64j]

Function
REQ-006 SHALL use this map: 0x00 ID (RO); 0x08 PULSE (WO, reads 0); 0x10+4i CTRL i; 0x40+8j STAT j low word; 0x44+8j STAT j high word.
REQ-007 SHALL register stat_in every cycle; all reads use this registered copy.
REQ-008 SHALL accept AW and W independently in either order or in the same cycle; awready is high while no address is held, wready is high while no data is held.
REQ-009 Write FSM SHALL have states W_IDLE, W_RESP: once both address and data are held, perform the write in that cycle and enter W_RESP with bvalid=1; return to W_IDLE on bready; awready=wready=0 in W_RESP.
REQ-010 SHALL apply wstrb byte masking to CTRL writes; writes to RO addresses have no effect.
REQ-011 A PULSE write SHALL drive pulse_out = wdata & byte-mask for exactly the cycle after the write, then 0.
REQ-012 Read FSM SHALL have states R_IDLE, R_DATA: arready=1 in R_IDLE; on AR handshake, latch rdata and enter R_DATA next cycle (rvalid one cycle after handshake); leave on rready.
REQ-013 A read of STAT j low word SHALL return the registered low word and simultaneously capture the registered high word into shadow j.
REQ-014 A read of STAT j high word SHALL return shadow j (the value coherent with the last low-word read of j).
REQ-015 Read and write channels SHALL be independent; same-cycle read and write of one CTRL address returns the pre-write value.
REQ-016 Addresses SHALL be decoded on bits [7:2]; bits [1:0] ignored.
REQ-017 bresp and rresp SHALL be 2'b00 except as given in REQ-021.

Reset
REQ-018 During rst: awready=wready=arready=0, bvalid=rvalid=0, pulse_out=0, all CTRL=CTRL_RESET, shadows=0, registered stats=0, held address/data discarded; readies assert the first cycle after rst deasserts.
REQ-019 rst asserted mid-transaction SHALL abort it without issuing a B or R response.

Configuration
REQ-020 Macro AXIL_STAT_REGS_SLVERR_EN selects unmapped-address handling.
REQ-021 With the macro defined: reads of unmapped addresses return rdata=0 with rresp=2'b10, writes to unmapped or RO addresses return bresp=2'b10. Without it: all responses are 2'b00 and unmapped reads return 0.

Verification
REQ-022 Reset, then read 0x00 -> rdata=32'h0002_0000, rresp=0; read 0x10 -> 32'h1.
REQ-023 W presented 3 cycles before AW, write 0x14 wdata=32'hAABBCCDD wstrb=4'b0101 -> one bvalid; read 0x14 -> 32'h00BB00DD; ctrl_out[63:32] matches.
REQ-024 stat_in[63:0]=64'h0000_0001_FFFF_FFFF; read 0x40 -> FFFFFFFF; set stat_in[63:0]=64'h2_0000_0000; read 0x44 -> 00000001 (shadow), not 00000002.
REQ-025 Write 0x08 wdata=32'h5 wstrb=4'hF -> pulse_out=5 for exactly one cycle, then 0; read 0x08 -> 0.
REQ-026 Read 0xFC: with AXIL_STAT_REGS_SLVERR_EN, rresp=2'b10, rdata=0; without it, rresp=0, rdata=0.
REQ-027 Assert rst while bvalid=1 and bready=0 -> bvalid=0 next cycle, ctrl_out returns to CTRL_RESET, no response after release.
